// File: rtl/vx_dcache_lane_arb_pkg.sv
// Shared types and width helpers for the dcache lane arbiter.
// The lane id rides in the LSBs of the memory-side tag.
package vx_dcache_lane_arb_pkg;

  function automatic int lane_bits(input int num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 1;
  endfunction

  function automatic int mem_tag_width(input int tag_width, input int num_reqs);
    return tag_width + lane_bits(num_reqs);
  endfunction

  // Request layout for the default build (4 lanes, 4-byte words, 30-bit address, 8-bit tag)
  typedef struct packed {
    logic        rw;
    logic [3:0]  byteen;
    logic [29:0] addr;
    logic [3:0]  flags;
    logic [31:0] data;
    logic [7:0]  tag;
  } req_t;

  typedef enum logic [1:0] {
    SB_EMPTY = 2'd0,
    SB_ONE   = 2'd1,
    SB_FULL  = 2'd2
  } sb_state_e;

endpackage

// File: rtl/vx_dcache_lane_arb_if.sv
// Core-side per-lane and memory-side single-port bundle for the lane arbiter.
// Per-lane fields are flattened, lane 0 in the LSBs.
interface vx_dcache_lane_arb_if
  import vx_dcache_lane_arb_pkg::*;
#(
  parameter int NUM_REQS    = 4,
  parameter int WORD_SIZE   = 4,
  parameter int ADDR_WIDTH  = 30,
  parameter int FLAGS_WIDTH = 4,
  parameter int TAG_WIDTH   = 8
);
  localparam int DATA_WIDTH    = WORD_SIZE * 8;
  localparam int MEM_TAG_WIDTH = mem_tag_width(TAG_WIDTH, NUM_REQS);

  logic [NUM_REQS-1:0]             core_req_valid;
  logic [NUM_REQS-1:0]             core_req_rw;
  logic [NUM_REQS*WORD_SIZE-1:0]   core_req_byteen;
  logic [NUM_REQS*ADDR_WIDTH-1:0]  core_req_addr;
  logic [NUM_REQS*FLAGS_WIDTH-1:0] core_req_flags;
  logic [NUM_REQS*DATA_WIDTH-1:0]  core_req_data;
  logic [NUM_REQS*TAG_WIDTH-1:0]   core_req_tag;
  logic [NUM_REQS-1:0]             core_req_ready;

  logic [NUM_REQS-1:0]             core_rsp_valid;
  logic [NUM_REQS*DATA_WIDTH-1:0]  core_rsp_data;
  logic [NUM_REQS*TAG_WIDTH-1:0]   core_rsp_tag;
  logic [NUM_REQS-1:0]             core_rsp_ready;

  logic                     mem_req_valid;
  logic                     mem_req_rw;
  logic [WORD_SIZE-1:0]     mem_req_byteen;
  logic [ADDR_WIDTH-1:0]    mem_req_addr;
  logic [FLAGS_WIDTH-1:0]   mem_req_flags;
  logic [DATA_WIDTH-1:0]    mem_req_data;
  logic [MEM_TAG_WIDTH-1:0] mem_req_tag;
  logic                     mem_req_ready;

  logic                     mem_rsp_valid;
  logic [DATA_WIDTH-1:0]    mem_rsp_data;
  logic [MEM_TAG_WIDTH-1:0] mem_rsp_tag;
  logic                     mem_rsp_ready;

  modport master (
    output core_req_valid, core_req_rw, core_req_byteen, core_req_addr,
    output core_req_flags, core_req_data, core_req_tag,
    input  core_req_ready,
    input  core_rsp_valid, core_rsp_data, core_rsp_tag,
    output core_rsp_ready,
    input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr,
    input  mem_req_flags, mem_req_data, mem_req_tag,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    input  mem_rsp_ready
  );

  modport slave (
    input  core_req_valid, core_req_rw, core_req_byteen, core_req_addr,
    input  core_req_flags, core_req_data, core_req_tag,
    output core_req_ready,
    output core_rsp_valid, core_rsp_data, core_rsp_tag,
    input  core_rsp_ready,
    output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr,
    output mem_req_flags, mem_req_data, mem_req_tag,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    output mem_rsp_ready
  );

endinterface

// File: rtl/vx_dcache_lane_arb_skid_buf.sv
// Two-entry valid/ready FIFO; the head register drives the output directly.
// Accepts a push whenever not full, so push+pop at one entry keeps occupancy.
module vx_dcache_lane_arb_skid_buf
  import vx_dcache_lane_arb_pkg::*;
#(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [DATAW-1:0] data_in,
  output logic             ready_in,
  output logic             valid_out,
  output logic [DATAW-1:0] data_out,
  input  logic             ready_out
);

  sb_state_e        state, state_next;
  logic [DATAW-1:0] head, tail;
  logic             push, pop;

  assign ready_in  = (state != SB_FULL);
  assign valid_out = (state != SB_EMPTY);
  assign data_out  = head;
  assign push      = valid_in & ready_in;
  assign pop       = valid_out & ready_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SB_EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      SB_EMPTY: if (push)         state_next = SB_ONE;
      SB_ONE:   if (push && !pop) state_next = SB_FULL;
                else if (!push && pop) state_next = SB_EMPTY;
      SB_FULL:  if (pop)          state_next = SB_ONE;
      default:                    state_next = SB_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (state == SB_EMPTY) head <= data_in;
          else                   tail <= data_in;
        end
        2'b01: head <= tail;
        // push with pop only happens at one entry (no push when full)
        2'b11: head <= data_in;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vx_dcache_lane_arb.sv
// Merges per-lane dcache channels onto one memory port with round-robin grant,
// a registered two-entry request buffer and tag-based response routing.
module vx_dcache_lane_arb
  import vx_dcache_lane_arb_pkg::*;
#(
  parameter int NUM_REQS    = 4,
  parameter int WORD_SIZE   = 4,
  parameter int ADDR_WIDTH  = 30,
  parameter int FLAGS_WIDTH = 4,
  parameter int TAG_WIDTH   = 8
) (
  input  logic               clk,
  input  logic               reset,
  vx_dcache_lane_arb_if.slave bus
);

  localparam int LANE_BITS     = lane_bits(NUM_REQS);
  localparam int MEM_TAG_WIDTH = mem_tag_width(TAG_WIDTH, NUM_REQS);
  localparam int DATA_WIDTH    = WORD_SIZE * 8;

  typedef struct packed {
    logic                     rw;
    logic [WORD_SIZE-1:0]     byteen;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [FLAGS_WIDTH-1:0]   flags;
    logic [DATA_WIDTH-1:0]    data;
    logic [MEM_TAG_WIDTH-1:0] tag;
  } lane_req_t;

  logic [LANE_BITS-1:0] rr_ptr, rr_ptr_next;
  logic [NUM_REQS-1:0]  rotated, grant;
  logic [LANE_BITS-1:0] grant_idx;
  logic                 grant_any, buf_ready, head_valid;
  lane_req_t            grant_req, head_req;

  // Rotate so the pointer lane sits at bit 0; first set bit is the winner.
  assign rotated = NUM_REQS'({bus.core_req_valid, bus.core_req_valid} >> rr_ptr);

  always_comb begin
    int unsigned offset;
    int unsigned sum;
    int unsigned nxt;
    offset    = 0;
    grant_any = 1'b0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (!grant_any && rotated[i]) begin
        grant_any = 1'b1;
        offset    = i;
      end
    end
    grant_any = grant_any & buf_ready & ~reset;
    sum = 32'(rr_ptr) + offset;
    if (sum >= NUM_REQS) sum = sum - NUM_REQS;
    nxt = sum + 1;
    if (nxt >= NUM_REQS) nxt = 0;
    grant_idx   = LANE_BITS'(sum);
    rr_ptr_next = LANE_BITS'(nxt);
  end

  always_comb begin
    grant = '0;
    for (int unsigned j = 0; j < NUM_REQS; j++)
      grant[j] = grant_any && (grant_idx == LANE_BITS'(j));
  end

  assign bus.core_req_ready = grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          rr_ptr <= '0;
    else if (grant_any) rr_ptr <= rr_ptr_next;
  end

  always_comb begin
    grant_req = '0;
    for (int unsigned j = 0; j < NUM_REQS; j++) begin
      if (grant[j]) begin
        grant_req.rw     = bus.core_req_rw[j];
        grant_req.byteen = bus.core_req_byteen[j*WORD_SIZE +: WORD_SIZE];
        grant_req.addr   = bus.core_req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
        grant_req.flags  = bus.core_req_flags[j*FLAGS_WIDTH +: FLAGS_WIDTH];
        grant_req.data   = bus.core_req_data[j*DATA_WIDTH +: DATA_WIDTH];
        grant_req.tag    = {bus.core_req_tag[j*TAG_WIDTH +: TAG_WIDTH], LANE_BITS'(j)};
      end
    end
  end

  vx_dcache_lane_arb_skid_buf #(
    .DATAW($bits(lane_req_t))
  ) req_buf (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (grant_any),
    .data_in   (grant_req),
    .ready_in  (buf_ready),
    .valid_out (head_valid),
    .data_out  (head_req),
    .ready_out (bus.mem_req_ready)
  );

  assign bus.mem_req_valid  = head_valid;
  assign bus.mem_req_rw     = head_req.rw;
  assign bus.mem_req_byteen = head_req.byteen;
  assign bus.mem_req_addr   = head_req.addr;
  assign bus.mem_req_flags  = head_req.flags;
  assign bus.mem_req_data   = head_req.data;
  assign bus.mem_req_tag    = head_req.tag;

  logic [LANE_BITS-1:0] rsp_lane;
  logic                 lane_ok;

  assign rsp_lane = bus.mem_rsp_tag[LANE_BITS-1:0];

  // An out-of-range lane id is swallowed: ready stays high, no lane sees valid.
  always_comb begin
    bus.core_rsp_valid = '0;
    bus.mem_rsp_ready  = 1'b1;
    lane_ok            = 1'b0;
    for (int unsigned j = 0; j < NUM_REQS; j++) begin
      if (rsp_lane == LANE_BITS'(j)) begin
        lane_ok               = 1'b1;
        bus.core_rsp_valid[j] = bus.mem_rsp_valid;
        bus.mem_rsp_ready     = bus.core_rsp_ready[j];
      end
    end
  end

  assign bus.core_rsp_data = {NUM_REQS{bus.mem_rsp_data}};
  assign bus.core_rsp_tag  = {NUM_REQS{bus.mem_rsp_tag[MEM_TAG_WIDTH-1:LANE_BITS]}};

  rsp_lane_legal: assert property (@(posedge clk) disable iff (reset) bus.mem_rsp_valid |-> lane_ok);

endmodule

// File: tb/tb_vx_dcache_lane_arb.sv
// Directed bench for vx_dcache_lane_arb: a 4-lane build and a 1-lane build.
module tb_vx_dcache_lane_arb;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  vx_dcache_lane_arb_if #(.NUM_REQS(4), .WORD_SIZE(4), .ADDR_WIDTH(30), .FLAGS_WIDTH(4), .TAG_WIDTH(8)) bus4 ();
  vx_dcache_lane_arb_if #(.NUM_REQS(1), .WORD_SIZE(4), .ADDR_WIDTH(30), .FLAGS_WIDTH(4), .TAG_WIDTH(8)) bus1 ();

  vx_dcache_lane_arb #(.NUM_REQS(4), .WORD_SIZE(4), .ADDR_WIDTH(30), .FLAGS_WIDTH(4), .TAG_WIDTH(8)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  vx_dcache_lane_arb #(.NUM_REQS(1), .WORD_SIZE(4), .ADDR_WIDTH(30), .FLAGS_WIDTH(4), .TAG_WIDTH(8)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input logic rw, input logic [3:0] be, input logic [29:0] a,
                          input logic [3:0] fl, input logic [31:0] d, input logic [7:0] t);
    bus4.core_req_rw[l]             = rw;
    bus4.core_req_byteen[l*4 +: 4]  = be;
    bus4.core_req_addr[l*30 +: 30]  = a;
    bus4.core_req_flags[l*4 +: 4]   = fl;
    bus4.core_req_data[l*32 +: 32]  = d;
    bus4.core_req_tag[l*8 +: 8]     = t;
  endtask

  task automatic clear_inputs();
    bus4.core_req_valid = '0; bus4.core_req_rw = '0; bus4.core_req_byteen = '0;
    bus4.core_req_addr  = '0; bus4.core_req_flags = '0; bus4.core_req_data = '0;
    bus4.core_req_tag   = '0; bus4.core_rsp_ready = '0; bus4.mem_req_ready = 1'b0;
    bus4.mem_rsp_valid  = 1'b0; bus4.mem_rsp_data = '0; bus4.mem_rsp_tag = '0;
    bus1.core_req_valid = '0; bus1.core_req_rw = '0; bus1.core_req_byteen = '0;
    bus1.core_req_addr  = '0; bus1.core_req_flags = '0; bus1.core_req_data = '0;
    bus1.core_req_tag   = '0; bus1.core_rsp_ready = '0; bus1.mem_req_ready = 1'b0;
    bus1.mem_rsp_valid  = 1'b0; bus1.mem_rsp_data = '0; bus1.mem_rsp_tag = '0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    bus4.core_req_valid = 4'hF;
    #2;
    chk("rst_core_req_ready", 64'(bus4.core_req_ready), 64'h0);
    chk("rst_mem_req_valid", 64'(bus4.mem_req_valid), 64'h0);
    chk("rst_mem_req_valid_1lane", 64'(bus1.mem_req_valid), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_core_req_ready_held", 64'(bus4.core_req_ready), 64'h0);
    chk("rst_mem_req_valid_held", 64'(bus4.mem_req_valid), 64'h0);
    bus4.core_req_valid = '0;
    reset = 1'b0;
    tick();

    // Fairness: all lanes valid, memory always ready -> 0,1,2,3,0,1,2,3
    for (int i = 0; i < 4; i++)
      set_lane(i, 1'b0, 4'hF, 30'(32'h10 + i), 4'h0, 32'(i), 8'(8'hA0 + i));
    bus4.core_req_valid = 4'hF;
    bus4.mem_req_ready  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("fair_grant", 64'(bus4.core_req_ready), 64'(1 << (k % 4)));
      if (k > 0) begin
        chk("fair_mem_valid", 64'(bus4.mem_req_valid), 64'h1);
        chk("fair_mem_addr", 64'(bus4.mem_req_addr), 64'(32'h10 + (k - 1) % 4));
        chk("fair_mem_tag", 64'(bus4.mem_req_tag), 64'(((32'hA0 + (k - 1) % 4) << 2) | ((k - 1) % 4)));
      end
      tick();
    end
    bus4.core_req_valid = '0;
    #1;
    chk("fair_last_valid", 64'(bus4.mem_req_valid), 64'h1);
    chk("fair_last_addr", 64'(bus4.mem_req_addr), 64'h13);
    tick();
    #1;
    chk("fair_drained", 64'(bus4.mem_req_valid), 64'h0);

    // Single lane 2 request with full payload pass-through
    set_lane(2, 1'b1, 4'b0011, 30'h100, 4'h9, 32'hCAFEF00D, 8'h5A);
    bus4.core_req_valid = 4'b0100;
    #1;
    chk("single_grant", 64'(bus4.core_req_ready), 64'h4);
    chk("single_not_yet_valid", 64'(bus4.mem_req_valid), 64'h0);
    tick();
    bus4.core_req_valid = '0;
    #1;
    chk("single_mem_valid", 64'(bus4.mem_req_valid), 64'h1);
    chk("single_mem_addr", 64'(bus4.mem_req_addr), 64'h100);
    chk("single_mem_tag", 64'(bus4.mem_req_tag), 64'h16A);
    chk("single_mem_rw", 64'(bus4.mem_req_rw), 64'h1);
    chk("single_mem_byteen", 64'(bus4.mem_req_byteen), 64'h3);
    chk("single_mem_flags", 64'(bus4.mem_req_flags), 64'h9);
    chk("single_mem_data", 64'(bus4.mem_req_data), 64'hCAFEF00D);
    tick();
    #1;
    chk("single_drained", 64'(bus4.mem_req_valid), 64'h0);

    // Backpressure: pointer is at 3, lanes 0,1 valid, memory stalled 5 cycles
    set_lane(0, 1'b0, 4'hF, 30'h200, 4'h0, 32'h1000, 8'h40);
    set_lane(1, 1'b0, 4'hF, 30'h201, 4'h0, 32'h1001, 8'h41);
    set_lane(2, 1'b0, 4'hF, 30'h202, 4'h0, 32'h1002, 8'h42);
    bus4.mem_req_ready  = 1'b0;
    bus4.core_req_valid = 4'b0011;
    #1;
    chk("bp_grant_lane0", 64'(bus4.core_req_ready), 64'h1);
    tick();
    #1;
    chk("bp_grant_lane1", 64'(bus4.core_req_ready), 64'h2);
    chk("bp_head_addr", 64'(bus4.mem_req_addr), 64'h200);
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_full_no_grant", 64'(bus4.core_req_ready), 64'h0);
      chk("bp_stall_valid", 64'(bus4.mem_req_valid), 64'h1);
      chk("bp_stall_addr", 64'(bus4.mem_req_addr), 64'h200);
      chk("bp_stall_tag", 64'(bus4.mem_req_tag), 64'h100);
      tick();
    end
    bus4.mem_req_ready  = 1'b1;
    bus4.core_req_valid = 4'b0101;
    #1;
    chk("bp_release_full", 64'(bus4.core_req_ready), 64'h0);
    chk("bp_release_addr", 64'(bus4.mem_req_addr), 64'h200);
    tick();
    #1;
    chk("bp_resume_lane2", 64'(bus4.core_req_ready), 64'h4);
    chk("bp_drain_addr1", 64'(bus4.mem_req_addr), 64'h201);
    chk("bp_drain_tag1", 64'(bus4.mem_req_tag), 64'h105);
    tick();
    bus4.core_req_valid = '0;
    #1;
    chk("bp_lane2_valid", 64'(bus4.mem_req_valid), 64'h1);
    chk("bp_lane2_addr", 64'(bus4.mem_req_addr), 64'h202);
    chk("bp_lane2_tag", 64'(bus4.mem_req_tag), 64'h10A);
    tick();
    #1;
    chk("bp_drained", 64'(bus4.mem_req_valid), 64'h0);

    // Response routing by lane id in tag LSBs
    bus4.mem_rsp_valid  = 1'b1;
    bus4.mem_rsp_tag    = 10'h0CF;
    bus4.mem_rsp_data   = 32'hDEADBEEF;
    bus4.core_rsp_ready = 4'b0111;
    #1;
    chk("rsp_valid_lane3", 64'(bus4.core_rsp_valid), 64'h8);
    chk("rsp_ready_blocked", 64'(bus4.mem_rsp_ready), 64'h0);
    chk("rsp_data_lane3", 64'(bus4.core_rsp_data[3*32 +: 32]), 64'hDEADBEEF);
    chk("rsp_data_lane0", 64'(bus4.core_rsp_data[0 +: 32]), 64'hDEADBEEF);
    chk("rsp_tag_lane3", 64'(bus4.core_rsp_tag[3*8 +: 8]), 64'h33);
    bus4.core_rsp_ready = 4'b1000;
    #1;
    chk("rsp_ready_lane3", 64'(bus4.mem_rsp_ready), 64'h1);
    bus4.mem_rsp_tag    = 10'h049;
    bus4.core_rsp_ready = 4'b0010;
    #1;
    chk("rsp_valid_lane1", 64'(bus4.core_rsp_valid), 64'h2);
    chk("rsp_ready_lane1", 64'(bus4.mem_rsp_ready), 64'h1);
    chk("rsp_tag_lane1", 64'(bus4.core_rsp_tag[1*8 +: 8]), 64'h12);
    bus4.mem_rsp_valid = 1'b0;
    #1;
    chk("rsp_idle", 64'(bus4.core_rsp_valid), 64'h0);
    bus4.core_rsp_ready = '0;
    tick();

    // Reset mid-flight: pointer at 3, fill buffer with lanes 3 then 1
    set_lane(1, 1'b0, 4'hF, 30'h301, 4'h0, 32'h0, 8'h51);
    set_lane(3, 1'b0, 4'hF, 30'h303, 4'h0, 32'h0, 8'h53);
    bus4.mem_req_ready  = 1'b0;
    bus4.core_req_valid = 4'b1010;
    #1;
    chk("mid_grant_lane3", 64'(bus4.core_req_ready), 64'h8);
    tick();
    #1;
    chk("mid_grant_lane1", 64'(bus4.core_req_ready), 64'h2);
    tick();
    #1;
    chk("mid_full", 64'(bus4.core_req_ready), 64'h0);
    chk("mid_head_addr", 64'(bus4.mem_req_addr), 64'h303);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid_drop", 64'(bus4.mem_req_valid), 64'h0);
    chk("mid_rst_ready_low", 64'(bus4.core_req_ready), 64'h0);
    #2;
    reset = 1'b0;
    set_lane(0, 1'b0, 4'hF, 30'h300, 4'h0, 32'h0, 8'h50);
    set_lane(2, 1'b0, 4'hF, 30'h302, 4'h0, 32'h0, 8'h52);
    bus4.core_req_valid = 4'hF;
    #1;
    chk("mid_after_rst_grant0", 64'(bus4.core_req_ready), 64'h1);
    chk("mid_after_rst_no_stale", 64'(bus4.mem_req_valid), 64'h0);
    tick();
    bus4.core_req_valid = '0;
    #1;
    chk("mid_after_rst_valid", 64'(bus4.mem_req_valid), 64'h1);
    chk("mid_after_rst_addr", 64'(bus4.mem_req_addr), 64'h300);
    chk("mid_after_rst_tag", 64'(bus4.mem_req_tag), 64'h140);
    bus4.mem_req_ready = 1'b1;
    tick();
    #1;
    chk("mid_after_rst_drained", 64'(bus4.mem_req_valid), 64'h0);

    // Single-lane build
    bus1.core_req_tag   = 8'hFF;
    bus1.core_req_addr  = 30'h3ABC;
    bus1.core_req_valid = 1'b1;
    bus1.mem_req_ready  = 1'b1;
    #1;
    chk("one_grant", 64'(bus1.core_req_ready), 64'h1);
    tick();
    bus1.core_req_valid = 1'b0;
    #1;
    chk("one_mem_valid", 64'(bus1.mem_req_valid), 64'h1);
    chk("one_mem_tag", 64'(bus1.mem_req_tag), 64'h1FE);
    chk("one_mem_addr", 64'(bus1.mem_req_addr), 64'h3ABC);
    tick();
    #1;
    chk("one_drained", 64'(bus1.mem_req_valid), 64'h0);
    bus1.mem_rsp_valid  = 1'b1;
    bus1.mem_rsp_tag    = 9'h1FE;
    bus1.mem_rsp_data   = 32'h12345678;
    bus1.core_rsp_ready = 1'b0;
    #1;
    chk("one_rsp_valid", 64'(bus1.core_rsp_valid), 64'h1);
    chk("one_rsp_blocked", 64'(bus1.mem_rsp_ready), 64'h0);
    chk("one_rsp_tag", 64'(bus1.core_rsp_tag), 64'hFF);
    chk("one_rsp_data", 64'(bus1.core_rsp_data), 64'h12345678);
    bus1.core_rsp_ready = 1'b1;
    #1;
    chk("one_rsp_ready", 64'(bus1.mem_rsp_ready), 64'h1);
    bus1.mem_rsp_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
